// File: rtl/fwd_hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit_pkg
//   Shared definitions for the forwarding / hazard controller and the EX-stage
//   operand muxes that consume its select codes.
//   - FWD_* : per-port operand source select codes.
//   - mdu_state_e : state encoding of the MDU scoreboard.
//   - fwd_pick() : priority encoder from stage-match flags to a select code.
// ----------------------------------------------------------------------------
package fwd_hazard_unit_pkg;

    // Operand source select codes (2 bits per read port)
    localparam logic [1:0] FWD_RF    = 2'b00;  // register file value
    localparam logic [1:0] FWD_EXMEM = 2'b10;  // ALU result sitting in EX/MEM
    localparam logic [1:0] FWD_MEMWB = 2'b01;  // write-back value in MEM/WB

    // MDU scoreboard states
    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    // EX/MEM is the newer producer, so it wins over MEM/WB when both match.
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_mdu_scoreboard.sv
// ----------------------------------------------------------------------------
// mdu_scoreboard
//   Tracks the single in-flight multi-cycle MDU operation.
//   Ports:
//     clk, reset     : rising-edge clock, synchronous active-high reset
//     start          : ID/EX instruction launches the MDU this cycle
//     start_rd       : destination register of the launching instruction
//     busy           : MDU op in flight (high for exactly MDU_LAT cycles)
//     dest           : destination of the in-flight op
//     done           : one-cycle pulse in the last busy cycle (result written)
//   A start while busy is ignored, except in the done cycle where it
//   re-launches immediately with the new destination.
// ----------------------------------------------------------------------------
module mdu_scoreboard
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int MDU_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [REG_AW-1:0] start_rd,
    output logic              busy,
    output logic [REG_AW-1:0] dest,
    output logic              done
);

    // MDU_LAT >= 2, so CW >= 1 and MDU_LAT-1 always fits.
    localparam int            CW       = $clog2(MDU_LAT);
    localparam logic [CW-1:0] CNT_INIT = CW'(MDU_LAT - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mdu_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] dest_q, dest_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state logic: launch, countdown, completion and back-to-back relaunch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    state_d = MDU_BUSY;
                    cnt_d   = CNT_INIT;
                    dest_d  = start_rd;
                    busy_d  = 1'b1;
                end else begin
                    state_d = MDU_IDLE;
                    busy_d  = 1'b0;
                end
            end
            MDU_BUSY: begin
                if (cnt_q == CNT_ZERO) begin
                    // Done cycle: a start here is legal and relaunches.
                    if (start) begin
                        state_d = MDU_BUSY;
                        cnt_d   = CNT_INIT;
                        dest_d  = start_rd;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = MDU_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    // Mid-flight start is ignored; done is registered one
                    // cycle ahead so it lines up with cnt reaching zero.
                    cnt_d  = cnt_q - CNT_ONE;
                    done_d = (cnt_q == CNT_ONE);
                end
            end
            default: begin
                state_d = MDU_IDLE;
                cnt_d   = CNT_ZERO;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= CNT_ZERO;
            dest_q  <= {REG_AW{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign dest = dest_q;
    assign done = done_q;

endmodule

// File: rtl/fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// fwd_hazard_unit
//   Forwarding and hazard controller for a 5-stage MIPS pipeline.
//   Inputs : ID-stage sources (id_src, id_src_used, id_mdu_op), ID/EX fields
//            (ex_src, ex_rd, ex_regwrite, ex_memread, ex_mdu_start),
//            EX/MEM and MEM/WB destinations with their regwrite flags.
//   Outputs: fwd_sel (2 bits per EX read port), stall_if_id / bubble_id_ex,
//            MDU status (mdu_busy, mdu_dest, mdu_done) and a saturating
//            stall-cycle counter stall_cnt.
//   While reset is high all control outputs are forced to their idle values.
// ----------------------------------------------------------------------------
module fwd_hazard_unit
    import fwd_hazard_unit_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int NUM_SRC     = 2,
    parameter int MDU_LAT     = 4,
    parameter int ZERO_REG_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_mdu_op,
    input  logic [NUM_SRC*REG_AW-1:0] ex_src,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic                      ex_regwrite,
    input  logic                      ex_memread,
    input  logic                      ex_mdu_start,
    input  logic [REG_AW-1:0]         mem_rd,
    input  logic                      mem_regwrite,
    input  logic [REG_AW-1:0]         wb_rd,
    input  logic                      wb_regwrite,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall_if_id,
    output logic                      bubble_id_ex,
    output logic                      mdu_busy,
    output logic [REG_AW-1:0]         mdu_dest,
    output logic                      mdu_done,
    output logic [CNT_W-1:0]          stall_cnt
);

    localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic              ZERO_EN  = (ZERO_REG_EN != 0);

    logic [2*NUM_SRC-1:0] fwd_raw;
    logic [NUM_SRC-1:0]   ld_hit;
    logic [NUM_SRC-1:0]   mdu_hit;
    logic                 sb_busy, sb_done;
    logic [REG_AW-1:0]    sb_dest;
    logic                 busy_g, done_g;
    logic                 ld_haz, mdu_haz, haz;
    logic                 dest_is_zero;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;

    mdu_scoreboard #(
        .REG_AW  (REG_AW),
        .MDU_LAT (MDU_LAT)
    ) u_mdu_sb (
        .clk      (clk),
        .reset    (reset),
        .start    (ex_mdu_start),
        .start_rd (ex_rd),
        .busy     (sb_busy),
        .dest     (sb_dest),
        .done     (sb_done)
    );

    // Reset forces the MDU status low even before the first reset edge.
    assign busy_g       = sb_busy & ~reset;
    assign done_g       = sb_done & ~reset;
    assign dest_is_zero = ZERO_EN && (sb_dest == REG_ZERO);

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_port
        logic [REG_AW-1:0] ex_s;
        logic [REG_AW-1:0] id_s;
        logic              mem_hit;
        logic              wb_hit;

        assign ex_s    = ex_src[k*REG_AW +: REG_AW];
        assign id_s    = id_src[k*REG_AW +: REG_AW];
        assign mem_hit = mem_regwrite && (mem_rd == ex_s);
        assign wb_hit  = wb_regwrite && (wb_rd == ex_s);

        // $0 is hard-wired zero, so a "write" to it must never be forwarded.
        assign fwd_raw[2*k +: 2] = (ZERO_EN && (ex_s == REG_ZERO)) ? FWD_RF
                                                                   : fwd_pick(mem_hit, wb_hit);

        assign ld_hit[k]  = id_src_used[k] && (id_s == ex_rd);
        assign mdu_hit[k] = id_src_used[k] && (id_s == sb_dest);
    end

    assign ld_haz = ex_memread && ex_regwrite && (ex_rd != REG_ZERO) && (|ld_hit);

    // A second MDU op may leave ID in the done cycle (unit frees up), but a
    // reader of the MDU result still waits through it.
    assign mdu_haz = busy_g && ((id_mdu_op && !done_g) || ((|mdu_hit) && !dest_is_zero));

    assign haz = (ld_haz | mdu_haz) & ~reset;

    // Saturating increment of the stall-cycle counter.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (haz && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall-counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel      = reset ? {(2*NUM_SRC){1'b0}} : fwd_raw;
    assign stall_if_id  = haz;
    assign bubble_id_ex = haz;
    assign mdu_busy     = busy_g;
    assign mdu_done     = done_g;
    assign mdu_dest     = sb_dest;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// ----------------------------------------------------------------------------
// tb_fwd_hazard_unit
//   Directed vectors driven one per cycle just after the rising edge; each
//   vector pushes its hand-computed expected outputs into a queue, and an
//   independent monitor pops and compares on the falling edge.
// ----------------------------------------------------------------------------
module tb_fwd_hazard_unit;

    localparam logic [5:0] M_FWD = 6'b000001;
    localparam logic [5:0] M_ST  = 6'b000010;
    localparam logic [5:0] M_BZ  = 6'b000100;
    localparam logic [5:0] M_DN  = 6'b001000;
    localparam logic [5:0] M_DS  = 6'b010000;
    localparam logic [5:0] M_CNT = 6'b100000;
    localparam logic [5:0] M_ALL = 6'b111111;
    localparam logic [5:0] M_RST = 6'b001111;

    typedef struct packed {
        logic [5:0]  mask;
        logic [3:0]  fwd;
        logic        st;
        logic        bz;
        logic        dn;
        logic [4:0]  ds;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [9:0]  id_src;
    logic [1:0]  id_src_used;
    logic        id_mdu_op;
    logic [9:0]  ex_src;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic        ex_mdu_start;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic [3:0]  fwd_sel;
    logic        stall_if_id;
    logic        bubble_id_ex;
    logic        mdu_busy;
    logic [4:0]  mdu_dest;
    logic        mdu_done;
    logic [15:0] stall_cnt;

    exp_t        exp_q[$];
    string       name_q[$];
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [15:0] cnt_model    = 16'd0;

    fwd_hazard_unit dut (
        .clk          (clk),
        .reset        (reset),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .id_mdu_op    (id_mdu_op),
        .ex_src       (ex_src),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .ex_memread   (ex_memread),
        .ex_mdu_start (ex_mdu_start),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .wb_rd        (wb_rd),
        .wb_regwrite  (wb_regwrite),
        .fwd_sel      (fwd_sel),
        .stall_if_id  (stall_if_id),
        .bubble_id_ex (bubble_id_ex),
        .mdu_busy     (mdu_busy),
        .mdu_dest     (mdu_dest),
        .mdu_done     (mdu_done),
        .stall_cnt    (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s.%s: act=%0h req=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: compares the vector of the current cycle on the falling edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if ((e.mask & M_FWD) != 6'd0) chk(nm, "fwd_sel", 32'(fwd_sel), 32'(e.fwd));
                if ((e.mask & M_ST) != 6'd0) begin
                    chk(nm, "stall_if_id", 32'(stall_if_id), 32'(e.st));
                    chk(nm, "bubble_id_ex", 32'(bubble_id_ex), 32'(e.st));
                end
                if ((e.mask & M_BZ) != 6'd0) chk(nm, "mdu_busy", 32'(mdu_busy), 32'(e.bz));
                if ((e.mask & M_DN) != 6'd0) chk(nm, "mdu_done", 32'(mdu_done), 32'(e.dn));
                if ((e.mask & M_DS) != 6'd0) chk(nm, "mdu_dest", 32'(mdu_dest), 32'(e.ds));
                if ((e.mask & M_CNT) != 6'd0) chk(nm, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Push expected outputs for this cycle; stall_cnt shows stalls of prior cycles.
    task automatic expect_out(input string nm, input logic [5:0] mask, input logic [3:0] f,
                              input logic st, input logic bz, input logic dn, input logic [4:0] ds);
        exp_t e;
        e.mask = mask;
        e.fwd  = f;
        e.st   = st;
        e.bz   = bz;
        e.dn   = dn;
        e.ds   = ds;
        e.cnt  = cnt_model;
        exp_q.push_back(e);
        name_q.push_back(nm);
        if (st && (cnt_model != 16'hFFFF)) cnt_model = cnt_model + 16'd1;
    endtask

    task automatic clr();
        id_src       = 10'd0;
        id_src_used  = 2'b00;
        id_mdu_op    = 1'b0;
        ex_src       = 10'd0;
        ex_rd        = 5'd0;
        ex_regwrite  = 1'b0;
        ex_memread   = 1'b0;
        ex_mdu_start = 1'b0;
        mem_rd       = 5'd0;
        mem_regwrite = 1'b0;
        wb_rd        = 5'd0;
        wb_regwrite  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clr();
        // Forwarding stimulus present during reset must be masked.
        mem_rd = 5'd8; mem_regwrite = 1'b1; ex_src = {5'd0, 5'd8};
        id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
        ex_rd = 5'd9; ex_regwrite = 1'b1; ex_memread = 1'b1;
        nxt();
        expect_out("rst0", M_RST, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt();
        cnt_model = 16'd0;
        expect_out("rst1", M_ALL, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

        // Forwarding priority
        nxt(); reset = 1'b0; clr();
        mem_rd = 5'd8; wb_rd = 5'd8; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
        ex_src = {5'd3, 5'd8};
        expect_out("fwd_exmem", M_ALL, 4'b0010, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); mem_regwrite = 1'b0;
        expect_out("fwd_memwb", M_FWD | M_ST, 4'b0001, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); mem_regwrite = 1'b1; mem_rd = 5'd7; ex_src = {5'd7, 5'd8};
        expect_out("fwd_mix", M_FWD, 4'b1001, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); mem_rd = 5'd0; wb_rd = 5'd0; ex_src = {5'd0, 5'd0};
        expect_out("fwd_zero", M_FWD, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

        // Load-use
        nxt(); clr();
        ex_rd = 5'd9; ex_memread = 1'b1; ex_regwrite = 1'b1;
        id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
        expect_out("ld_use0", M_ST | M_CNT, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0);
        nxt(); ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        expect_out("ld_bubble", M_ST | M_CNT, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); ex_rd = 5'd9; ex_memread = 1'b1; ex_regwrite = 1'b1; id_src_used = 2'b00;
        expect_out("ld_unused", M_ST, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); id_src = {5'd9, 5'd4}; id_src_used = 2'b10;
        expect_out("ld_use1", M_ST, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0);
        nxt(); ex_rd = 5'd0; id_src = {5'd0, 5'd0}; id_src_used = 2'b11;
        expect_out("ld_rd0", M_ST | M_CNT, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

        // MDU dependent stall: start rd=12 at T
        nxt(); clr();
        ex_mdu_start = 1'b1; ex_rd = 5'd12; ex_regwrite = 1'b1;
        id_src = {5'd0, 5'd12}; id_src_used = 2'b01;
        expect_out("mdu_T", M_ST | M_BZ | M_DN, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); ex_mdu_start = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
        expect_out("mdu_T1", M_ALL, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd12);
        nxt(); expect_out("mdu_T2", M_ST | M_BZ | M_DN, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd12);
        nxt(); expect_out("mdu_T3", M_ST | M_BZ | M_DN, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd12);
        nxt(); expect_out("mdu_T4", M_ALL, 4'b0000, 1'b1, 1'b1, 1'b1, 5'd12);
        nxt(); expect_out("mdu_T5", M_ALL, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd12);

        // MDU structural stall, back-to-back relaunch, ignored mid-flight start
        nxt(); clr(); ex_mdu_start = 1'b1; ex_rd = 5'd13;
        expect_out("b2b_T", M_BZ, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); ex_mdu_start = 1'b0; ex_rd = 5'd0; id_mdu_op = 1'b1;
        expect_out("b2b_T1", M_ST | M_BZ | M_DS, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd13);
        nxt(); expect_out("b2b_T2", M_ST, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd13);
        nxt(); expect_out("b2b_T3", M_ST | M_DN, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd13);
        nxt(); ex_mdu_start = 1'b1; ex_rd = 5'd14;
        expect_out("b2b_T4", M_ALL, 4'b0000, 1'b0, 1'b1, 1'b1, 5'd13);
        nxt(); ex_mdu_start = 1'b0; ex_rd = 5'd0; id_mdu_op = 1'b0;
        expect_out("b2b_T5", M_ALL, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd14);
        nxt(); ex_mdu_start = 1'b1; ex_rd = 5'd20;
        expect_out("ign_T6", M_BZ | M_DN | M_DS, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd14);
        nxt(); ex_mdu_start = 1'b0; ex_rd = 5'd0;
        expect_out("ign_T7", M_BZ | M_DN | M_DS, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd14);
        nxt(); expect_out("ign_T8", M_BZ | M_DN | M_DS, 4'b0000, 1'b0, 1'b1, 1'b1, 5'd14);
        nxt(); expect_out("ign_T9", M_BZ | M_DN | M_CNT, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd14);

        // MDU writing $0 never stalls a reader of $0
        nxt(); clr(); ex_mdu_start = 1'b1; ex_rd = 5'd0;
        id_src = {5'd0, 5'd0}; id_src_used = 2'b11;
        expect_out("z_T", M_BZ, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); ex_mdu_start = 1'b0;
        expect_out("z_T1", M_ST | M_BZ | M_DS, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd0);
        nxt(); expect_out("z_T2", M_ST, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd0);
        nxt(); expect_out("z_T3", M_ST, 4'b0000, 1'b0, 1'b1, 1'b0, 5'd0);
        nxt(); expect_out("z_T4", M_ST | M_DN, 4'b0000, 1'b0, 1'b1, 1'b1, 5'd0);

        // Reset mid-MDU
        nxt(); clr(); ex_mdu_start = 1'b1; ex_rd = 5'd15;
        id_src = {5'd0, 5'd15}; id_src_used = 2'b01;
        expect_out("ra_T", M_BZ | M_CNT, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); ex_mdu_start = 1'b0; ex_rd = 5'd0;
        expect_out("ra_T1", M_ST | M_BZ | M_DS, 4'b0000, 1'b1, 1'b1, 1'b0, 5'd15);
        nxt(); reset = 1'b1; mem_rd = 5'd3; mem_regwrite = 1'b1; ex_src = {5'd3, 5'd3};
        expect_out("ra_T2", M_RST, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        cnt_model = 16'd0;
        nxt(); reset = 1'b0; mem_regwrite = 1'b0;
        expect_out("ra_T3", M_ALL, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);
        nxt(); expect_out("ra_T4", M_BZ | M_DN | M_CNT, 4'b0000, 1'b0, 1'b0, 1'b0, 5'd0);

        // Saturation: continuous load-use stall for 2^16+5 cycles
        nxt(); clr();
        ex_rd = 5'd9; ex_memread = 1'b1; ex_regwrite = 1'b1;
        id_src = {5'd0, 5'd9}; id_src_used = 2'b01;
        for (int i = 0; i < 65541; i++) nxt();
        cnt_model = 16'hFFFF;
        expect_out("sat0", M_ST | M_CNT, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0);
        nxt(); expect_out("sat1", M_ST | M_CNT, 4'b0000, 1'b1, 1'b0, 1'b0, 5'd0);

        nxt(); clr();
        @(negedge clk);
        #1;
        chk("drain", "queue_size", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
